// File: rtl/hdmi_pkg.sv
// Shared constants, types and helpers for the HDMI display-side read path.
// Holds default 640x480@60 timing, pipeline depth and colour-bar table.
package hdmi_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_MEM_LINE = DEF_H_ACTIVE / 2;
   localparam logic DEF_SYNC_POL = 1'b0;

   localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP
                          + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP
                          + DEF_V_SYNC + DEF_V_BP;
   localparam int RD_LAT  = 3;
   localparam int BAR_W   = 80;

   typedef logic [23:0] rgb_t;

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
   } vid_ctl_t;

   function automatic rgb_t nib_expand(input logic [11:0] p);
      return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
   endfunction

   function automatic logic [2:0] bar_idx(input logic [9:0] hc);
      logic [2:0] i;
      i = 3'd0;
      for (int b = 1; b < 8; b++)
         if (hc >= 10'(b * BAR_W)) i = 3'(b);
      return i;
   endfunction

   function automatic rgb_t bar_color(input logic [2:0] i);
      rgb_t c;
      unique case (i)
         3'd0: c = 24'hFFFFFF;
         3'd1: c = 24'hFFFF00;
         3'd2: c = 24'h00FFFF;
         3'd3: c = 24'h00FF00;
         3'd4: c = 24'hFF00FF;
         3'd5: c = 24'hFF0000;
         3'd6: c = 24'h0000FF;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/hdmi_read_ctrl_if.sv
// Frame-buffer read port plus HDMI encoder video bus.
// master = read controller, slave = buffer/encoder side.
interface hdmi_read_ctrl_if;
   import hdmi_pkg::*;

   logic        HVsync;
   logic        HMemRead;
   logic [18:0] Mem_Read_Add;
   logic [11:0] HDMIdata;
   logic        vid_hsync;
   logic        vid_vsync;
   logic        vid_de;
   rgb_t        vid_data;

   modport master (
      output HVsync, HMemRead, Mem_Read_Add,
      input  HDMIdata,
      output vid_hsync, vid_vsync, vid_de, vid_data
   );

   modport slave (
      input  HVsync, HMemRead, Mem_Read_Add,
      output HDMIdata,
      input  vid_hsync, vid_vsync, vid_de, vid_data
   );

endinterface

// File: rtl/video_timing_gen.sv
// Free-running h/v raster counters with raw active and sync-window decode.
// Sync flags are 1 inside the window regardless of output polarity.
module video_timing_gen
   import hdmi_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic       Hclk,
   input  logic       rstn,
   output logic [9:0] hcnt,
   output logic       active,
   output logic       v_act,
   output logic       hs,
   output logic       vs,
   output logic       line_end,
   output logic       frame_end
);

   localparam logic [9:0] HA  = 10'(H_ACTIVE);
   localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] HL  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] VA  = 10'(V_ACTIVE);
   localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] VL  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   logic [9:0] vcnt;

   assign line_end  = (hcnt == HL);
   assign frame_end = line_end && (vcnt == VL);
   assign v_act     = (vcnt < VA);
   assign active    = (hcnt < HA) && v_act;
   assign hs        = (hcnt >= HS0) && (hcnt < HS1);
   assign vs        = (vcnt >= VS0) && (vcnt < VS1);

   always_ff @(posedge Hclk or negedge rstn) begin
      if (!rstn) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (line_end) begin
         hcnt <= '0;
         vcnt <= frame_end ? '0 : vcnt + 10'd1;
      end else begin
         hcnt <= hcnt + 10'd1;
      end
   end

endmodule

// File: rtl/hdmi_read_ctrl.sv
// HDMI read controller: frame-buffer address generation and 3-stage video pipe.
// Define HDMI_TEST_PATTERN_EN to add test_mode and the 8-bar colour pattern.
module hdmi_read_ctrl
   import hdmi_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter int   MEM_LINE = DEF_MEM_LINE,
   parameter logic SYNC_POL = DEF_SYNC_POL
) (
   input logic Hclk,
   input logic rstn,
`ifdef HDMI_TEST_PATTERN_EN
   input logic test_mode,
`endif
   hdmi_read_ctrl_if.master hdmi
);

   logic [9:0]  hcnt;
   logic        active, v_act, hs, vs;
   logic        line_end, frame_end;
   logic [18:0] line_base, rd_addr;
   vid_ctl_t    s1, s2;
   rgb_t        pix;

   video_timing_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP),
      .H_SYNC   (H_SYNC),   .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP),
      .V_SYNC   (V_SYNC),   .V_BP (V_BP)
   ) u_timing (
      .Hclk      (Hclk),
      .rstn      (rstn),
      .hcnt      (hcnt),
      .active    (active),
      .v_act     (v_act),
      .hs        (hs),
      .vs        (vs),
      .line_end  (line_end),
      .frame_end (frame_end)
   );

   // Each stored word feeds two adjacent pixels, hence hcnt/2.
   assign rd_addr = line_base + 19'(hcnt >> 1);

   always_ff @(posedge Hclk or negedge rstn) begin
      if (!rstn)
         line_base <= '0;
      else if (frame_end)
         line_base <= '0;
      else if (line_end && v_act)
         line_base <= line_base + 19'(MEM_LINE);
   end

   always_ff @(posedge Hclk or negedge rstn) begin
      if (!rstn) begin
         hdmi.HMemRead     <= 1'b0;
         hdmi.Mem_Read_Add <= '0;
         hdmi.HVsync       <= 1'b0;
         s1                <= '0;
         s2                <= '0;
      end else begin
         hdmi.HMemRead     <= active;
         hdmi.Mem_Read_Add <= active ? rd_addr : '0;
         hdmi.HVsync       <= v_act;
         s1                <= '{de: active, hs: hs, vs: vs};
         s2                <= s1;
      end
   end

`ifdef HDMI_TEST_PATTERN_EN
   logic [9:0] hc1, hc2;

   always_ff @(posedge Hclk or negedge rstn) begin
      if (!rstn) begin
         hc1 <= '0;
         hc2 <= '0;
      end else begin
         hc1 <= hcnt;
         hc2 <= hc1;
      end
   end

   assign pix = test_mode ? bar_color(bar_idx(hc2))
                          : nib_expand(hdmi.HDMIdata);
`else
   assign pix = nib_expand(hdmi.HDMIdata);
`endif

   always_ff @(posedge Hclk or negedge rstn) begin
      if (!rstn) begin
         hdmi.vid_de    <= 1'b0;
         hdmi.vid_hsync <= ~SYNC_POL;
         hdmi.vid_vsync <= ~SYNC_POL;
         hdmi.vid_data  <= '0;
      end else begin
         hdmi.vid_de    <= s2.de;
         hdmi.vid_hsync <= s2.hs ? SYNC_POL : ~SYNC_POL;
         hdmi.vid_vsync <= s2.vs ? SYNC_POL : ~SYNC_POL;
         hdmi.vid_data  <= s2.de ? pix : '0;
      end
   end

endmodule

// File: tb/tb_hdmi_read_ctrl.sv
// Scoreboard bench for hdmi_read_ctrl: raster model vs DUT, every clock.
// Short vertical timing keeps one frame at 24800 clocks.
module tb_hdmi_read_ctrl;

   localparam int HA  = 640;
   localparam int HFP = 16;
   localparam int HSY = 96;
   localparam int HBP = 48;
   localparam int VA  = 24;
   localparam int VFP = 2;
   localparam int VSY = 2;
   localparam int VBP = 3;
   localparam int HT  = HA + HFP + HSY + HBP;
   localparam int VT  = VA + VFP + VSY + VBP;
   localparam int ML  = HA / 2;
   localparam int MSZ = VA * ML;

   typedef struct {
      logic        hvs;
      logic        rd;
      logic [18:0] addr;
      logic        de;
      logic        hs;
      logic        vs;
      logic [23:0] data;
   } exp_t;

   logic Hclk = 1'b0;
   logic rstn = 1'b0;
   logic test_mode = 1'b0;
   logic [11:0] mem [MSZ];
   logic [23:0] bars [8];
   exp_t q [$];
   int   edges = 0;
   logic tm_edge = 1'b0;
   int   tests = 0;
   int   fails = 0;

   hdmi_read_ctrl_if bus ();

   hdmi_read_ctrl #(
      .H_ACTIVE (HA),  .H_FP   (HFP),
      .H_SYNC   (HSY), .H_BP   (HBP),
      .V_ACTIVE (VA),  .V_FP   (VFP),
      .V_SYNC   (VSY), .V_BP   (VBP),
      .MEM_LINE (ML),  .SYNC_POL (1'b0)
   ) dut (
      .Hclk      (Hclk),
      .rstn      (rstn),
`ifdef HDMI_TEST_PATTERN_EN
      .test_mode (test_mode),
`endif
      .hdmi      (bus)
   );

   always #5 Hclk = ~Hclk;

   // frame buffer: registered read, data valid one clock after address
   always @(posedge Hclk) begin
      int a;
      a = int'(bus.Mem_Read_Add);
      bus.HDMIdata <= (a < MSZ) ? mem[a[12:0]] : 12'h000;
   end

   always @(posedge Hclk) begin
      if (!rstn) edges = 0;
      else edges++;
`ifdef HDMI_TEST_PATTERN_EN
      tm_edge = test_mode;
`else
      tm_edge = 1'b0;
`endif
   end

   function automatic exp_t expect_at(input int k, input logic tm);
      exp_t e;
      int n, x, y, idx;
      logic [11:0] w;
      e.hvs = 1'b0; e.rd = 1'b0; e.addr = '0;
      e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.data = '0;
      if (k >= 1) begin
         n = k - 1;
         x = n % HT;
         y = (n / HT) % VT;
         e.hvs = (y < VA);
         e.rd = (x < HA) && (y < VA);
         e.addr = e.rd ? 19'(y * ML + x / 2) : 19'd0;
      end
      if (k >= 3) begin
         n = k - 3;
         x = n % HT;
         y = (n / HT) % VT;
         e.de = (x < HA) && (y < VA);
         e.hs = !(x >= HA + HFP && x < HA + HFP + HSY);
         e.vs = !(y >= VA + VFP && y < VA + VFP + VSY);
         if (e.de) begin
            idx = y * ML + x / 2;
            w = mem[idx[12:0]];
            e.data = tm ? bars[x / 80]
                        : {w[11:8], w[11:8], w[7:4], w[7:4],
                           w[3:0], w[3:0]};
         end
      end
      return e;
   endfunction

   always @(negedge Hclk)
      q.push_back(rstn ? expect_at(edges, tm_edge) : expect_at(0, 1'b0));

   task automatic chk(input string nm, input logic [23:0] got,
                      input logic [23:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         if (fails <= 20)
            $display("FAIL %s edge=%0d got=%h exp=%h",
                     nm, edges, got, exp);
      end
   endtask

   always @(negedge Hclk) begin
      exp_t e;
      #1;
      if (q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard_empty edge=%0d got=0 exp=1", edges);
      end else begin
         e = q.pop_front();
         chk("HVsync",   24'(bus.HVsync),       24'(e.hvs));
         chk("HMemRead", 24'(bus.HMemRead),     24'(e.rd));
         chk("addr",     24'(bus.Mem_Read_Add), 24'(e.addr));
         chk("vid_de",   24'(bus.vid_de),       24'(e.de));
         chk("hsync",    24'(bus.vid_hsync),    24'(e.hs));
         chk("vsync",    24'(bus.vid_vsync),    24'(e.vs));
         chk("vid_data", bus.vid_data,          e.data);
      end
   end

   initial begin
      bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00;
      bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
      bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000;
      bars[6] = 24'h0000FF; bars[7] = 24'h000000;
      for (int i = 0; i < MSZ; i++) mem[i] = 12'($urandom);
      mem[0] = 12'hA5C;
      rstn = 1'b0;
      repeat (3) @(posedge Hclk);
      #2 rstn = 1'b1;
      // full frame, then into line 10 of the next one at hcnt 300
      repeat (HT * VT + 10 * HT + 300) @(posedge Hclk);
      #2 rstn = 1'b0;
      repeat ($urandom_range(1, 4)) @(posedge Hclk);
      #2 rstn = 1'b1;
      repeat (3 * HT) @(posedge Hclk);
`ifdef HDMI_TEST_PATTERN_EN
      #2 test_mode = 1'b1;
      repeat (2 * HT) @(posedge Hclk);
`endif
      @(negedge Hclk);
      #2;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
